blood_bank_matcher: RTL and testbench
=====================================

BLOOD_BANK_MATCHER -- requirements
Module: blood_bank_matcher

Interface
REQ-001 SHALL take parameter CNT_W, default 4: inventory counter width per blood type (max stock 2^CNT_W-1 units).
REQ-002 SHALL take parameter STAT_W, default 16: statistics counter width (used only with BLOOD_BANK_STATS_EN).
REQ-003 SHALL have a single clock and a synchronous, active-low reset.
REQ-004 clk  in  1  single clock; all logic samples on the rising edge.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 donValid  in  1  donation unit present this cycle; always accepted.
REQ-007 donType  in  3  donated blood type.
REQ-008 donOverflow  out  1  one-cycle pulse: donation dropped because stock is saturated.
REQ-009 reqValid  in  1  recipient request valid.
REQ-010 reqType  in  3  recipient blood type.
REQ-011 reqReady  out  1  high only in IDLE.
REQ-012 respValid  out  1  response valid; held until respReady.
REQ-013 respReady  in  1  consumer accepts the response.
REQ-014 respGrant  out  1  1 = unit issued, 0 = denied.
REQ-015 respType  out  3  donor type issued; 0 when denied.
REQ-016 stockSel  in  3  inventory query index.
REQ-017 stockLevel  out  CNT_W  combinational read of the count for stockSel.
REQ-018 grantCount / denyCount  out  STAT_W each  saturating statistics counters.

Function
REQ-019 Type encoding: [2:1] ABO (00 O, 01 A, 10 B, 11 AB); [0] Rh (1 = positive).
REQ-020 Donor d SHALL be compatible with recipient r iff (d[2:1] & ~r[2:1]) == 0 and d[0] <= r[0].
REQ-021 Eight counters (one per type) SHALL hold the stock, each CNT_W bits wide.
REQ-022 A donation SHALL increment count[donType], saturating at the maximum; at saturation donOverflow SHALL pulse the next cycle and the count SHALL NOT change.
REQ-023 FSM states SHALL be IDLE, SCAN and RESP.
REQ-024 IDLE->SCAN when reqValid is high; reqType SHALL be latched and the step counter cleared.
REQ-025 SCAN step 0 SHALL check candidate reqType; steps 1..8 SHALL check candidates 7 down to 0; one candidate SHALL be checked per cycle.
REQ-026 A candidate hits if it is compatible and its count is nonzero.
REQ-027 On a hit: decrement that count, set respGrant=1 and respType=candidate, go to RESP.
REQ-028 After step 8 with no hit: set respGrant=0 and respType=0, go to RESP.
REQ-029 Latency: if the request is accepted at cycle T and hits at step s, respValid SHALL rise at T+2+s; a deny SHALL assert at T+10.
REQ-030 RESP->IDLE on respReady; respValid, respGrant and respType SHALL stay stable while stalled.
REQ-031 A donation and a grant decrement on the same type in the same cycle SHALL leave the count unchanged, with no overflow even when the count is at maximum.
REQ-032 A donation arriving during SCAN SHALL be visible to candidates checked in later cycles.

Reset
REQ-033 When rst_n=0 at a clock edge: FSM to IDLE; all counts to 0; respValid, respGrant, respType and donOverflow to 0; statistics counters to 0.
REQ-034 Reset during SCAN or RESP SHALL abort the operation silently; any in-flight decrement SHALL be lost with the counts.
REQ-035 reqReady SHALL be 1 in the first cycle after reset release.

Configuration
REQ-036 With macro BLOOD_BANK_STATS_EN defined: grantCount and denyCount SHALL increment (saturating at 2^STAT_W-1) in the cycle RESP is entered.
REQ-037 Without BLOOD_BANK_STATS_EN: both ports SHALL be tied to 0 and no statistics registers SHALL exist.

Structure
REQ-038 Shared package blood_bank_pkg SHALL hold the ABO/Rh encoding constants, the FSM state encoding and the SCAN_LAST=8 constant.
REQ-039 A combinational sub-module blood_compat SHALL implement REQ-020 (inputs donor and recipient type; output compatible).

Verification
REQ-040 Reset, 3 donations of type 3 (A+), request 3 -> respValid at T+2, grant=1, type=3, stockLevel[3]=2.
REQ-041 Stock only type 0 (O-): request 7 (AB+) -> steps 0..7 miss and step 8 hits, grant=1, type=0 at T+10.
REQ-042 Stock only type 7: request 0 -> grant=0, type=0 at T+10; denyCount=1 with BLOOD_BANK_STATS_EN.
REQ-043 With CNT_W=4: 16 donations of type 5 -> count=15, donOverflow pulses once; donation of type 5 in the same cycle as a grant of type 5 -> count stays 15, no pulse.
REQ-044 respReady held low for 5 cycles -> response held stable and reqReady=0; rst_n=0 asserted mid-SCAN -> IDLE with all counts 0 on the next cycle.

Source files
------------

// File: rtl/blood_bank_pkg.sv
// Shared definitions for the blood bank matcher: blood type encoding,
// FSM state encoding and scan sequencing constants.
package blood_bank_pkg;

   // ABO group occupies bits [2:1] of a blood type, Rh factor occupies bit [0]
   localparam logic [1:0] ABO_O  = 2'b00;
   localparam logic [1:0] ABO_A  = 2'b01;
   localparam logic [1:0] ABO_B  = 2'b10;
   localparam logic [1:0] ABO_AB = 2'b11;
   localparam logic       RH_NEG = 1'b0;
   localparam logic       RH_POS = 1'b1;

   localparam int NUM_TYPES = 8;
   // Step 0 checks the requested type, steps 1..SCAN_LAST walk types 7 down to 0
   localparam int SCAN_LAST = 8;
   localparam int STEP_W    = 4;

   typedef logic [2:0] bloodType_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      RESP = 2'd2
   } fsmState_t;

   function automatic logic [1:0] aboOf(input bloodType_t t);
      return t[2:1];
   endfunction

   function automatic logic rhOf(input bloodType_t t);
      return t[0];
   endfunction

endpackage

// File: rtl/blood_bank_matcher_if.sv
// Donation, request/response and inventory query signals of the blood bank
// matcher. The slave modport is the matcher, the master modport its user.
interface blood_bank_matcher_if
   import blood_bank_pkg::*;
#(
   parameter int CNT_W  = 4,
   parameter int STAT_W = 16
);

   logic              donValid;
   bloodType_t        donType;
   logic              donOverflow;
   logic              reqValid;
   bloodType_t        reqType;
   logic              reqReady;
   logic              respValid;
   logic              respReady;
   logic              respGrant;
   bloodType_t        respType;
   bloodType_t        stockSel;
   logic [CNT_W-1:0]  stockLevel;
   logic [STAT_W-1:0] grantCount;
   logic [STAT_W-1:0] denyCount;

   modport slave (
      input  donValid, donType, reqValid, reqType, respReady, stockSel,
      output donOverflow, reqReady, respValid, respGrant, respType,
             stockLevel, grantCount, denyCount
   );

   modport master (
      output donValid, donType, reqValid, reqType, respReady, stockSel,
      input  donOverflow, reqReady, respValid, respGrant, respType,
             stockLevel, grantCount, denyCount
   );

endinterface

// File: rtl/blood_compat.sv
// Donor/recipient compatibility: the donor may not carry an antigen the
// recipient lacks, and an Rh-positive donor needs an Rh-positive recipient.
module blood_compat
   import blood_bank_pkg::*;
(
   input  bloodType_t donor,
   input  bloodType_t recipient,
   output logic       compatible
);

   logic aboOk;
   logic rhOk;

   // Pure combinational compatibility check
   always_comb begin
      aboOk      = (aboOf(donor) & ~aboOf(recipient)) == ABO_O;
      rhOk       = !((rhOf(donor) == RH_POS) && (rhOf(recipient) == RH_NEG));
      compatible = aboOk && rhOk;
   end

endmodule

// File: rtl/blood_bank_matcher.sv
// Blood bank matcher: keeps a per-type unit inventory fed by donations and
// serves one recipient request at a time by scanning candidate donor types,
// one per cycle, issuing the first compatible type that has stock.
// Optional feature: define BLOOD_BANK_STATS_EN to build the saturating
// grant/deny statistics counters; otherwise both outputs are tied to zero.
module blood_bank_matcher
   import blood_bank_pkg::*;
#(
   parameter int CNT_W  = 4,
   parameter int STAT_W = 16
)(
   input logic                clk,
   input logic                rst_n,
   blood_bank_matcher_if.slave bus
);

   fsmState_t          state;
   fsmState_t          nextState;
   bloodType_t         reqLatched;
   bloodType_t         candType;
   logic [STEP_W-1:0]  step;
   logic [CNT_W-1:0]   count [NUM_TYPES];
   logic               candCompat;
   logic               candStocked;
   logic               scanHit;
   logic               scanDone;
   logic [NUM_TYPES-1:0] incVec;
   logic [NUM_TYPES-1:0] decVec;
   logic [NUM_TYPES-1:0] satVec;
   logic               overflowNext;
   logic               donOverflowQ;
   logic               respGrantQ;
   bloodType_t         respTypeQ;
   logic               reqReadyC;
   logic               respValidC;

   // Candidate under test this cycle and whether it can be issued
   always_comb begin
      candType    = (step == '0) ? reqLatched : 3'(SCAN_LAST - int'(step));
      candStocked = count[candType] != '0;
      scanHit     = (state == SCAN) && candCompat && candStocked;
      scanDone    = step == STEP_W'(SCAN_LAST);
   end

   blood_compat u_compat (
      .donor      (candType),
      .recipient  (reqLatched),
      .compatible (candCompat)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of process ordering.
      if (!rst_n) state <= IDLE;
      else        state <= nextState;
   end

   // FSM next-state logic
   always_comb begin
      // NOTE: default assignment first so no path leaves nextState unassigned,
      // which would otherwise infer a latch.
      nextState = state;
      unique case (state)
         IDLE: if (bus.reqValid)            nextState = SCAN;
         SCAN: if (scanHit || scanDone)     nextState = RESP;
         RESP: if (bus.respReady)           nextState = IDLE;
         default:                           nextState = IDLE;
      endcase
   end

   // FSM outputs decoded from the current state
   always_comb begin
      reqReadyC  = state == IDLE;
      respValidC = state == RESP;
   end

   // Request latch, scan step counter and registered response fields
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         reqLatched <= '0;
         step       <= '0;
         respGrantQ <= 1'b0;
         respTypeQ  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.reqValid) begin
                  reqLatched <= bus.reqType;
                  step       <= '0;
               end
            end
            SCAN: begin
               if (scanHit) begin
                  respGrantQ <= 1'b1;
                  respTypeQ  <= candType;
               end else if (scanDone) begin
                  respGrantQ <= 1'b0;
                  respTypeQ  <= '0;
               end else begin
                  step <= step + STEP_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Per-type increment/decrement requests and saturation flags
   always_comb begin
      incVec       = '0;
      decVec       = '0;
      satVec       = '0;
      overflowNext = 1'b0;
      for (int i = 0; i < NUM_TYPES; i++) begin
         incVec[i] = bus.donValid && (bus.donType == 3'(i));
         decVec[i] = scanHit && (candType == 3'(i));
         satVec[i] = count[i] == '1;
      end
      // A simultaneous grant on the same type absorbs the donation
      overflowNext = |(incVec & ~decVec & satVec);
   end

   // Inventory counters and the overflow pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: the stock array is reset element by element because a reset
         // must leave the bank empty; this keeps it in flops, not RAM.
         for (int i = 0; i < NUM_TYPES; i++) count[i] <= '0;
         donOverflowQ <= 1'b0;
      end else begin
         donOverflowQ <= overflowNext;
         for (int i = 0; i < NUM_TYPES; i++) begin
            if (decVec[i] && !incVec[i])
               count[i] <= count[i] - CNT_W'(1);
            else if (incVec[i] && !decVec[i] && !satVec[i])
               count[i] <= count[i] + CNT_W'(1);
         end
      end
   end

`ifdef BLOOD_BANK_STATS_EN
   logic [STAT_W-1:0] grantCountQ;
   logic [STAT_W-1:0] denyCountQ;
   logic              enterResp;

   assign enterResp = (state == SCAN) && (nextState == RESP);

   // Saturating grant/deny tallies bumped as each response is formed
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         grantCountQ <= '0;
         denyCountQ  <= '0;
      end else if (enterResp) begin
         if (scanHit) begin
            if (grantCountQ != '1) grantCountQ <= grantCountQ + STAT_W'(1);
         end else begin
            if (denyCountQ != '1)  denyCountQ  <= denyCountQ + STAT_W'(1);
         end
      end
   end

   assign bus.grantCount = grantCountQ;
   assign bus.denyCount  = denyCountQ;
`else
   assign bus.grantCount = {STAT_W{1'b0}};
   assign bus.denyCount  = {STAT_W{1'b0}};
`endif

   assign bus.reqReady    = reqReadyC;
   assign bus.respValid   = respValidC;
   assign bus.respGrant   = respGrantQ;
   assign bus.respType    = respTypeQ;
   assign bus.donOverflow = donOverflowQ;
   assign bus.stockLevel  = count[bus.stockSel];

endmodule

// File: tb/tb_blood_bank_matcher.sv
// Directed self-checking bench for blood_bank_matcher. Latencies are counted
// in clock edges after the edge that accepts the request: a hit at scan step s
// is seen after 1+s edges, a deny after 9 edges.
module tb_blood_bank_matcher;
   import blood_bank_pkg::*;

   localparam int CNT_W  = 4;
   localparam int STAT_W = 16;

   logic clk = 1'b0;
   logic rst_n;
   always #10 clk = ~clk;

   blood_bank_matcher_if #(.CNT_W(CNT_W), .STAT_W(STAT_W)) bus ();

   blood_bank_matcher #(.CNT_W(CNT_W), .STAT_W(STAT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int expGrant = 0;
   int expDeny  = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs();
      bus.donValid  = 1'b0;
      bus.donType   = '0;
      bus.reqValid  = 1'b0;
      bus.reqType   = '0;
      bus.respReady = 1'b1;
      bus.stockSel  = '0;
   endtask

   task automatic resetDut();
      rst_n = 1'b0;
      idleInputs();
      tick();
      tick();
      rst_n = 1'b1;
      expGrant = 0;
      expDeny  = 0;
   endtask

   task automatic donate(input bloodType_t t, input int n);
      bus.donValid = 1'b1;
      bus.donType  = t;
      repeat (n) tick();
      bus.donValid = 1'b0;
   endtask

   task automatic readStock(input bloodType_t t, output logic [CNT_W-1:0] lvl);
      bus.stockSel = t;
      #1;
      lvl = bus.stockLevel;
   endtask

   // Issues a request and waits (bounded) for respValid; lat = -1 on timeout
   task automatic runRequest(input bloodType_t t, output int lat,
                             output logic g, output bloodType_t rt);
      bus.reqValid = 1'b1;
      bus.reqType  = t;
      tick();
      bus.reqValid = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (bus.respValid === 1'b1) begin
            lat = i;
            break;
         end
      end
      g  = bus.respGrant;
      rt = bus.respType;
   endtask

   task automatic test_reset();
      logic [CNT_W-1:0] lvl;
      resetDut();
      checks++; if (bus.reqReady !== 1'b1) begin errors++; $display("FAIL reset_reqReady got %b exp 1", bus.reqReady); end
      checks++; if (bus.respValid !== 1'b0) begin errors++; $display("FAIL reset_respValid got %b exp 0", bus.respValid); end
      checks++; if (bus.respGrant !== 1'b0) begin errors++; $display("FAIL reset_respGrant got %b exp 0", bus.respGrant); end
      checks++; if (bus.respType !== 3'd0) begin errors++; $display("FAIL reset_respType got %0d exp 0", bus.respType); end
      checks++; if (bus.donOverflow !== 1'b0) begin errors++; $display("FAIL reset_donOverflow got %b exp 0", bus.donOverflow); end
      for (int i = 0; i < 8; i++) begin
         readStock(3'(i), lvl);
         checks++; if (lvl !== '0) begin errors++; $display("FAIL reset_stock[%0d] got %0d exp 0", i, lvl); end
      end
      checks++; if (bus.grantCount !== '0) begin errors++; $display("FAIL reset_grantCount got %0d exp 0", bus.grantCount); end
      checks++; if (bus.denyCount !== '0) begin errors++; $display("FAIL reset_denyCount got %0d exp 0", bus.denyCount); end
   endtask

   task automatic test_basic_grant();
      int lat; logic g; bloodType_t rt; logic [CNT_W-1:0] lvl;
      resetDut();
      donate(3'd3, 3);
      readStock(3'd3, lvl);
      checks++; if (lvl !== 4'd3) begin errors++; $display("FAIL basic_stock_before got %0d exp 3", lvl); end
      runRequest(3'd3, lat, g, rt);
      checks++; if (lat != 1) begin errors++; $display("FAIL basic_latency got %0d exp 1", lat); end
      checks++; if (g !== 1'b1) begin errors++; $display("FAIL basic_grant got %b exp 1", g); end
      checks++; if (rt !== 3'd3) begin errors++; $display("FAIL basic_type got %0d exp 3", rt); end
      readStock(3'd3, lvl);
      checks++; if (lvl !== 4'd2) begin errors++; $display("FAIL basic_stock_after got %0d exp 2", lvl); end
      tick();
      checks++; if (bus.reqReady !== 1'b1) begin errors++; $display("FAIL basic_back_idle got %b exp 1", bus.reqReady); end
   endtask

   task automatic test_fallback();
      int lat; logic g; bloodType_t rt; logic [CNT_W-1:0] lvl;
      resetDut();
      donate(3'd0, 1);
      runRequest(3'd7, lat, g, rt);
      checks++; if (lat != 9) begin errors++; $display("FAIL fallback_latency got %0d exp 9", lat); end
      checks++; if (g !== 1'b1) begin errors++; $display("FAIL fallback_grant got %b exp 1", g); end
      checks++; if (rt !== 3'd0) begin errors++; $display("FAIL fallback_type got %0d exp 0", rt); end
      readStock(3'd0, lvl);
      checks++; if (lvl !== 4'd0) begin errors++; $display("FAIL fallback_stock got %0d exp 0", lvl); end
      tick();
   endtask

   task automatic test_deny();
      int lat; logic g; bloodType_t rt; logic [CNT_W-1:0] lvl;
      resetDut();
      donate(3'd7, 1);
      runRequest(3'd0, lat, g, rt);
      expDeny++;
      checks++; if (lat != 9) begin errors++; $display("FAIL deny_latency got %0d exp 9", lat); end
      checks++; if (g !== 1'b0) begin errors++; $display("FAIL deny_grant got %b exp 0", g); end
      checks++; if (rt !== 3'd0) begin errors++; $display("FAIL deny_type got %0d exp 0", rt); end
      readStock(3'd7, lvl);
      checks++; if (lvl !== 4'd1) begin errors++; $display("FAIL deny_stock7 got %0d exp 1", lvl); end
`ifdef BLOOD_BANK_STATS_EN
      checks++; if (bus.denyCount !== 16'(expDeny)) begin errors++; $display("FAIL deny_denyCount got %0d exp %0d", bus.denyCount, expDeny); end
      checks++; if (bus.grantCount !== 16'(expGrant)) begin errors++; $display("FAIL deny_grantCount got %0d exp %0d", bus.grantCount, expGrant); end
`else
      checks++; if (bus.denyCount !== '0) begin errors++; $display("FAIL deny_denyCount_tied got %0d exp 0", bus.denyCount); end
`endif
      tick();
   endtask

   task automatic test_priority();
      int lat; logic g; bloodType_t rt;
      int expLat [4]  = '{4, 8, 9, 9};
      logic expG [4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
      bloodType_t expT [4] = '{3'd5, 3'd1, 3'd0, 3'd0};
      bloodType_t reqT [4] = '{3'd7, 3'd7, 3'd3, 3'd3};
      resetDut();
      donate(3'd0, 1);
      donate(3'd1, 1);
      donate(3'd5, 1);
      for (int k = 0; k < 4; k++) begin
         runRequest(reqT[k], lat, g, rt);
         if (expG[k]) expGrant++; else expDeny++;
         checks++; if (lat != expLat[k]) begin errors++; $display("FAIL prio%0d_latency got %0d exp %0d", k, lat, expLat[k]); end
         checks++; if (g !== expG[k]) begin errors++; $display("FAIL prio%0d_grant got %b exp %b", k, g, expG[k]); end
         checks++; if (rt !== expT[k]) begin errors++; $display("FAIL prio%0d_type got %0d exp %0d", k, rt, expT[k]); end
         tick();
      end
`ifdef BLOOD_BANK_STATS_EN
      checks++; if (bus.grantCount !== 16'(expGrant)) begin errors++; $display("FAIL prio_grantCount got %0d exp %0d", bus.grantCount, expGrant); end
      checks++; if (bus.denyCount !== 16'(expDeny)) begin errors++; $display("FAIL prio_denyCount got %0d exp %0d", bus.denyCount, expDeny); end
`else
      checks++; if (bus.grantCount !== '0) begin errors++; $display("FAIL prio_grantCount_tied got %0d exp 0", bus.grantCount); end
`endif
   endtask

   task automatic test_scan_donation();
      int lat; logic [CNT_W-1:0] lvl;
      resetDut();
      bus.reqValid = 1'b1;
      bus.reqType  = 3'd0;
      tick();
      bus.reqValid = 1'b0;
      tick();
      bus.donValid = 1'b1;
      bus.donType  = 3'd0;
      tick();
      bus.donValid = 1'b0;
      lat = -1;
      for (int i = 3; i <= 20; i++) begin
         tick();
         if (bus.respValid === 1'b1) begin lat = i; break; end
      end
      checks++; if (lat != 9) begin errors++; $display("FAIL scandon_latency got %0d exp 9", lat); end
      checks++; if (bus.respGrant !== 1'b1) begin errors++; $display("FAIL scandon_grant got %b exp 1", bus.respGrant); end
      checks++; if (bus.respType !== 3'd0) begin errors++; $display("FAIL scandon_type got %0d exp 0", bus.respType); end
      readStock(3'd0, lvl);
      checks++; if (lvl !== 4'd0) begin errors++; $display("FAIL scandon_stock got %0d exp 0", lvl); end
      tick();
   endtask

   task automatic test_overflow();
      int pulses; int pulseAt; logic [CNT_W-1:0] lvl;
      resetDut();
      pulses  = 0;
      pulseAt = -1;
      bus.donValid = 1'b1;
      bus.donType  = 3'd5;
      for (int i = 1; i <= 18; i++) begin
         if (i == 17) bus.donValid = 1'b0;
         tick();
         if (bus.donOverflow === 1'b1) begin pulses++; pulseAt = i; end
      end
      checks++; if (pulses != 1) begin errors++; $display("FAIL ovf_pulse_count got %0d exp 1", pulses); end
      checks++; if (pulseAt != 16) begin errors++; $display("FAIL ovf_pulse_donation got %0d exp 16", pulseAt); end
      readStock(3'd5, lvl);
      checks++; if (lvl !== 4'd15) begin errors++; $display("FAIL ovf_stock got %0d exp 15", lvl); end
      // Grant of type 5 and donation of type 5 land on the same edge
      bus.reqValid = 1'b1;
      bus.reqType  = 3'd5;
      tick();
      bus.reqValid = 1'b0;
      bus.donValid = 1'b1;
      bus.donType  = 3'd5;
      tick();
      bus.donValid = 1'b0;
      checks++; if (bus.respValid !== 1'b1) begin errors++; $display("FAIL same_respValid got %b exp 1", bus.respValid); end
      checks++; if (bus.respGrant !== 1'b1 || bus.respType !== 3'd5) begin errors++; $display("FAIL same_resp got grant %b type %0d exp grant 1 type 5", bus.respGrant, bus.respType); end
      checks++; if (bus.donOverflow !== 1'b0) begin errors++; $display("FAIL same_overflow got %b exp 0", bus.donOverflow); end
      readStock(3'd5, lvl);
      checks++; if (lvl !== 4'd15) begin errors++; $display("FAIL same_stock got %0d exp 15", lvl); end
      tick();
      checks++; if (bus.donOverflow !== 1'b0) begin errors++; $display("FAIL same_overflow_late got %b exp 0", bus.donOverflow); end
   endtask

   task automatic test_stall();
      int lat; logic g; bloodType_t rt; logic [CNT_W-1:0] lvl;
      resetDut();
      donate(3'd2, 1);
      bus.respReady = 1'b0;
      runRequest(3'd2, lat, g, rt);
      checks++; if (lat != 1 || g !== 1'b1 || rt !== 3'd2) begin errors++; $display("FAIL stall_resp got lat %0d grant %b type %0d exp lat 1 grant 1 type 2", lat, g, rt); end
      bus.reqValid = 1'b1;
      bus.reqType  = 3'd0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (bus.respValid !== 1'b1 || bus.respGrant !== 1'b1 || bus.respType !== 3'd2 || bus.reqReady !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold%0d got valid %b grant %b type %0d ready %b exp 1 1 2 0",
                     i, bus.respValid, bus.respGrant, bus.respType, bus.reqReady);
         end
      end
      bus.reqValid  = 1'b0;
      bus.respReady = 1'b1;
      tick();
      checks++; if (bus.respValid !== 1'b0 || bus.reqReady !== 1'b1) begin errors++; $display("FAIL stall_release got valid %b ready %b exp 0 1", bus.respValid, bus.reqReady); end
      readStock(3'd2, lvl);
      checks++; if (lvl !== 4'd0) begin errors++; $display("FAIL stall_stock got %0d exp 0", lvl); end
   endtask

   task automatic test_reset_mid_scan();
      logic [CNT_W-1:0] lvl;
      int bad;
      resetDut();
      donate(3'd4, 2);
      bus.reqValid = 1'b1;
      bus.reqType  = 3'd7;
      tick();
      bus.reqValid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      checks++; if (bus.reqReady !== 1'b1) begin errors++; $display("FAIL midrst_reqReady got %b exp 1", bus.reqReady); end
      checks++; if (bus.respValid !== 1'b0 || bus.respGrant !== 1'b0 || bus.respType !== 3'd0) begin errors++; $display("FAIL midrst_resp got valid %b grant %b type %0d exp 0 0 0", bus.respValid, bus.respGrant, bus.respType); end
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         readStock(3'(i), lvl);
         if (lvl !== '0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL midrst_stock got %0d nonzero types exp 0", bad); end
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.respValid !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL midrst_abort got %0d cycles with respValid exp 0", bad); end
   endtask

   initial begin
      rst_n = 1'b0;
      idleInputs();
      test_reset();
      test_basic_grant();
      test_fallback();
      test_deny();
      test_priority();
      test_scan_donation();
      test_overflow();
      test_stall();
      test_reset_mid_scan();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
